// File: rtl/seg7_pkg.sv
// Shared glyphs and slot indices for the multiplexed 7-segment scanner.
// Segment bits are active-high a..g at bits 0..6; the top module inverts them for the pins.
package seg7_pkg;
    localparam int NSLOT = 8;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_H     = 7'h76;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [2:0] SLOT_SEC_0 = 3'd3;
    localparam logic [2:0] SLOT_MIN_0 = 3'd5;
    localparam logic [2:0] SLOT_STAT  = 3'd7;
endpackage

// File: rtl/seg7_dec.sv
// BCD to active-high segment decoder; codes above 9 show a dash, blank forces all segments off.
// Purely combinational.
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (code)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end
endmodule

// File: rtl/seg7_scan.sv
// 8-digit common-anode scanner: digits 0..6 show the stopwatch time, digit 7 a status glyph.
// Inputs are snapshotted once per frame; pin outputs are registered one cycle behind the counters.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DPN = 8,
    parameter int DPL = $clog2(DPN),
    parameter int GAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       t_mil_0,
    input  logic [3:0]       t_mil_1,
    input  logic [3:0]       t_mil_2,
    input  logic [3:0]       t_sec_0,
    input  logic [3:0]       t_sec_1,
    input  logic [3:0]       t_min_0,
    input  logic [3:0]       t_min_1,
    input  logic             s_run,
    input  logic             s_hld,
    output logic [NSLOT-1:0] an_n,
    output logic [6:0]       seg_n,
    output logic             dp_n
);
    localparam logic [DPL-1:0] TICK_LAST = DPL'(DPN - 1);
    localparam logic [DPL:0]   DRIVE_END = (DPL + 1)'(DPN - GAP);

    logic [DPL-1:0] tick;
    logic [2:0]     slot;
    logic [3:0]     snap [7];
    logic           snap_run, snap_hld;
    logic           frame_end, drive;
    logic           blank4, blank5, blank6;
    logic [3:0]     digit;
    logic           digit_blank, dp_on;
    logic [6:0]     dec_seg, seg_sel;

    assign frame_end = (tick == TICK_LAST) && (slot == SLOT_STAT);
    assign drive     = {1'b0, tick} < DRIVE_END;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= '0;
            slot <= '0;
        end else if (tick == TICK_LAST) begin
            tick <= '0;
            slot <= slot + 3'd1;
        end else begin
            tick <= tick + DPL'(1);
        end
    end

    // Frame-boundary capture keeps one coherent time value on screen for a whole scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) snap[i] <= '0;
            snap_run <= 1'b0;
            snap_hld <= 1'b0;
        end else if (frame_end) begin
            snap[0]  <= t_mil_0;
            snap[1]  <= t_mil_1;
            snap[2]  <= t_mil_2;
            snap[3]  <= t_sec_0;
            snap[4]  <= t_sec_1;
            snap[5]  <= t_min_0;
            snap[6]  <= t_min_1;
            snap_run <= s_run;
            snap_hld <= s_hld;
        end
    end

    // Equality with zero only, so an invalid code stops the blanking chain.
    assign blank6 = (snap[6] == 4'd0);
    assign blank5 = blank6 && (snap[5] == 4'd0);
    assign blank4 = blank5 && (snap[4] == 4'd0);

    always_comb begin
        digit       = 4'd0;
        digit_blank = 1'b0;
        case (slot)
            3'd0: digit = snap[0];
            3'd1: digit = snap[1];
            3'd2: digit = snap[2];
            3'd3: digit = snap[3];
            3'd4: begin digit = snap[4]; digit_blank = blank4; end
            3'd5: begin digit = snap[5]; digit_blank = blank5; end
            3'd6: begin digit = snap[6]; digit_blank = blank6; end
            default: digit_blank = 1'b1;
        endcase
    end

    seg7_dec u_dec (
        .code  (digit),
        .blank (digit_blank),
        .seg   (dec_seg)
    );

    always_comb begin
        seg_sel = dec_seg;
        if (slot == SLOT_STAT) begin
            if (snap_hld)      seg_sel = SEG_H;
            else if (snap_run) seg_sel = SEG_R;
            else               seg_sel = SEG_BLANK;
        end
    end

    assign dp_on = (slot == SLOT_SEC_0) || ((slot == SLOT_MIN_0) && !blank5);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_n  <= '1;
            seg_n <= '1;
            dp_n  <= 1'b1;
        end else if (drive) begin
            an_n  <= ~(NSLOT'(1) << slot);
            seg_n <= ~seg_sel;
            dp_n  <= ~dp_on;
        end else begin
            an_n  <= '1;
            seg_n <= '1;
            dp_n  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: per-cycle reference model, vector table of whole frames, and corner sequences.
module tb_seg7_scan;
    localparam int DPN   = 8;
    localparam int FRAME = DPN * 8;

    typedef struct packed {
        logic [27:0] digs;   // {min1,min0,sec1,sec0,mil2,mil1,mil0}
        logic        run;
        logic        hld;
        logic [55:0] segs;   // active-low seg_n, slot 7 in the top bits
        logic [7:0]  dpn;    // expected dp_n per slot
    } vec_t;

    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    logic       clk, rst;
    logic [3:0] dig [7];
    logic       s_run, s_hld;
    logic [7:0] an_n, an0_n;
    logic [6:0] seg_n, seg0_n;
    logic       dp_n, dp0_n;

    int checks, errors, cyc, ff_cnt, ff0_cnt;
    logic [3:0] msnap [7];
    logic       mrun, mhld;
    logic [6:0] obs_seg [8];
    logic       obs_dp [8];
    vec_t       vecs [7];

    seg7_scan #(.DPN(DPN), .GAP(1)) dut (
        .clk(clk), .rst(rst),
        .t_mil_0(dig[0]), .t_mil_1(dig[1]), .t_mil_2(dig[2]), .t_sec_0(dig[3]),
        .t_sec_1(dig[4]), .t_min_0(dig[5]), .t_min_1(dig[6]),
        .s_run(s_run), .s_hld(s_hld), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
    );

    seg7_scan #(.DPN(DPN), .GAP(0)) dut0 (
        .clk(clk), .rst(rst),
        .t_mil_0(dig[0]), .t_mil_1(dig[1]), .t_mil_2(dig[2]), .t_sec_0(dig[3]),
        .t_sec_1(dig[4]), .t_min_0(dig[5]), .t_min_1(dig[6]),
        .s_run(s_run), .s_hld(s_hld), .an_n(an0_n), .seg_n(seg0_n), .dp_n(dp0_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: display contents derived from the snapshot time value and the scan position.
    function automatic void exp_out(input int k, input int gap, output logic [7:0] an,
                                    output logic [6:0] seg, output logic dp);
        int tk, sl, lz;
        logic blank;
        logic [6:0] g;
        tk = k % DPN;
        sl = (k / DPN) % 8;
        an = 8'hFF; seg = 7'h7F; dp = 1'b1;
        if (tk < DPN - gap) begin
            an = 8'hFF ^ (8'd1 << sl);
            if (sl == 7) begin
                g = mhld ? 7'h76 : (mrun ? 7'h50 : 7'h00);
            end else begin
                lz = 0;
                for (int j = 6; j >= 4; j--)
                    if (lz == 6 - j && msnap[j] == 4'd0) lz++;
                blank = (sl >= 4) && ((6 - sl) < lz);
                g = blank ? 7'h00 : GLYPH[msnap[sl]];
                dp = !((sl == 3 || sl == 5) && !blank);
            end
            seg = ~g;
        end
    endfunction

    task automatic tick1();
        logic [7:0] ea, ea0;
        logic [6:0] es, es0;
        logic       ed, ed0;
        int cs, ct;
        @(posedge clk);
        exp_out(cyc, 1, ea, es, ed);
        exp_out(cyc, 0, ea0, es0, ed0);
        if (cyc % FRAME == FRAME - 1) begin
            for (int i = 0; i < 7; i++) msnap[i] = dig[i];
            mrun = s_run;
            mhld = s_hld;
        end
        cs = (cyc / DPN) % 8;
        ct = cyc % DPN;
        cyc++;
        @(negedge clk);
        chk("an_n", an_n, ea);
        chk("seg_n", {1'b0, seg_n}, {1'b0, es});
        chk("dp_n", {7'd0, dp_n}, {7'd0, ed});
        chk("gap0 an_n", an0_n, ea0);
        chk("gap0 seg_n", {1'b0, seg0_n}, {1'b0, es0});
        chk("gap0 dp_n", {7'd0, dp0_n}, {7'd0, ed0});
        if (ct == 0) begin
            obs_seg[cs] = seg_n;
            obs_dp[cs]  = dp_n;
        end
        if (an_n == 8'hFF) ff_cnt++;
        if (an0_n == 8'hFF) ff0_cnt++;
    endtask

    task automatic set_inputs(input logic [27:0] digs, input logic run, input logic hld);
        for (int i = 0; i < 7; i++) dig[i] = digs[4*i +: 4];
        s_run = run;
        s_hld = hld;
    endtask

    task automatic run_frame(input bit pre);
        if (pre) tick1();
        while (cyc % FRAME != 0) tick1();
        ff_cnt = 0;
        ff0_cnt = 0;
        repeat (FRAME) tick1();
    endtask

    task automatic chk_frame(input vec_t v);
        for (int s = 0; s < 8; s++) begin
            chk($sformatf("frame slot %0d seg_n", s), {1'b0, obs_seg[s]}, {1'b0, v.segs[7*s +: 7]});
            chk($sformatf("frame slot %0d dp_n", s), {7'd0, obs_dp[s]}, {7'd0, v.dpn[s]});
        end
        chk("gap1 off cycles per frame", 8'(ff_cnt), 8'd8);
        chk("gap0 off cycles per frame", 8'(ff0_cnt), 8'd0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        #1;
        chk("reset an_n", an_n, 8'hFF);
        chk("reset seg_n", {1'b0, seg_n}, 8'h7F);
        chk("reset dp_n", {7'd0, dp_n}, 8'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 7; i++) msnap[i] = 4'd0;
        mrun = 1'b0;
        mhld = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; ff_cnt = 0; ff0_cnt = 0;
        rst = 1'b0;
        set_inputs(28'h0, 1'b0, 1'b0);

        vecs[0] = '{28'h0000000, 1'b0, 1'b0,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40}, 8'b1111_0111};
        vecs[1] = '{28'h1234567, 1'b1, 1'b0,
                    {7'h2F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}, 8'b1101_0111};
        vecs[2] = '{28'h0005000, 1'b0, 1'b0,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40, 7'h40, 7'h40}, 8'b1111_0111};
        vecs[3] = '{28'h10000C0, 1'b1, 1'b1,
                    {7'h09, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h40}, 8'b1101_0111};
        vecs[4] = '{28'hF000000, 1'b1, 1'b0,
                    {7'h2F, 7'h3F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'b1101_0111};
        vecs[5] = '{28'h00E0000, 1'b0, 1'b0,
                    {7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h40, 7'h40, 7'h40}, 8'b1111_0111};
        vecs[6] = '{28'h0900000, 1'b0, 1'b1,
                    {7'h09, 7'h7F, 7'h10, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'b1101_0111};

        #2;
        reset_dut();

        // First frame after reset shows the zero snapshot.
        run_frame(1'b0);
        chk_frame(vecs[0]);

        for (int v = 0; v < 7; v++) begin
            set_inputs(vecs[v].digs, vecs[v].run, vecs[v].hld);
            run_frame(1'b1);
            chk_frame(vecs[v]);
        end

        // Mid-frame change of seconds: old value this frame, new value next frame.
        set_inputs(vecs[1].digs, 1'b1, 1'b0);
        run_frame(1'b1);
        repeat (2 * DPN) tick1();
        dig[3] = 4'd9;
        repeat (FRAME - 2 * DPN) tick1();
        chk("mid-frame slot3 old value", {1'b0, obs_seg[3]}, 8'h19);
        repeat (FRAME) tick1();
        chk("next frame slot3 new value", {1'b0, obs_seg[3]}, 8'h10);

        // Reset in the middle of slot 4, then scan restarts from slot 0 with a zero snapshot.
        while (cyc % FRAME != 4 * DPN + 4) tick1();
        chk("slot4 driven before reset", an_n, 8'hEF);
        reset_dut();
        run_frame(1'b0);
        chk_frame(vecs[0]);

        // Randomized inputs, biased toward zeros to exercise blanking.
        repeat (1600) begin
            if ($urandom_range(0, 15) == 0) begin
                for (int i = 0; i < 7; i++)
                    dig[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                s_run = 1'($urandom_range(0, 1));
                s_hld = 1'($urandom_range(0, 1));
            end
            tick1();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
